command_response_tx: RTL and testbench
======================================

// Module: command_response_tx
// PURPOSE
//   Transmit side of the host command byte stream. Frames response packets (ACK, ERR,
//   STATUS) and drives them byte-serially onto the cmd_out valid/ready interface.
//   Sits between the command parser/status sources and the host link transmitter.
//   Owns the cmd_out_valid/cmd_out_data outputs of the command path.
// PARAMETERS
//   STATUS_BYTES  4      payload length of a STATUS frame in bytes, legal range 1..16
//   OP_ACK        8'hC0  ACK frame opcode
//   OP_ERR        8'hE0  ERR frame opcode
//   OP_STATUS     8'hD0  STATUS frame opcode
// PORTS
//   clk             in   1                  system clock, rising edge
//   rstn            in   1                  asynchronous active-low reset
//   ack_valid       in   1                  ACK request for a completed command
//   ack_ready       out  1                  ACK request accepted
//   ack_cmd         in   8 (byte_t)         opcode being acknowledged
//   err_valid       in   1                  ERR request for a rejected/unknown command
//   err_ready       out  1                  ERR request accepted
//   err_cmd         in   8 (byte_t)         offending opcode
//   status_valid    in   1                  STATUS request
//   status_ready    out  1                  STATUS request accepted
//   status_data     in   STATUS_BYTES*8     status word, sent MSB byte first
//   cmd_out_valid   out  1                  output byte valid
//   cmd_out_ready   in   1                  host link accepts byte
//   cmd_out_data    out  8 (byte_t)         output byte
// BEHAVIOUR
//   - Clock clk; reset rstn asynchronous, active-low. Reset: state=IDLE, cmd_out_valid=0,
//     cmd_out_data=0, all *_ready=0, byte counter=0, frame regs=0. Reset mid-frame aborts
//     the frame silently; no partial-frame completion after release.
//   - Frame formats: ACK = {OP_ACK, ack_cmd}; ERR = {OP_ERR, err_cmd};
//     STATUS = {OP_STATUS, status_data[top byte] .. status_data[byte 0]}.
//   - States: IDLE -> HEADER -> PAYLOAD -> IDLE.
//     IDLE: *_ready combinationally high only for the selected requester; fixed priority
//       err > ack > status. On accept (valid&&ready) latch opcode+payload, go HEADER.
//       Lower-priority requests are not accepted that cycle (ready=0).
//     HEADER: cmd_out_valid=1, data=opcode. On cmd_out_valid&&cmd_out_ready -> PAYLOAD,
//       byte counter := frame payload length - 1.
//     PAYLOAD: data=current payload byte; on transfer decrement counter; transfer with
//       counter==0 -> IDLE (or CHECKSUM when enabled).
//   - *_ready is 0 in every state except IDLE: one request in flight max.
//   - Latency: request accepted at cycle N -> header valid at N+1. With cmd_out_ready
//     held high, an ACK frame occupies 2 output cycles; back-to-back frames have exactly
//     one IDLE bubble cycle between last byte and next header.
//   - cmd_out_data and cmd_out_valid are registered; while valid=1 and ready=0, data
//     holds stable; valid never drops without a transfer (except reset).
//   - Request inputs are sampled only at accept; later changes to *_cmd/status_data
//     do not affect the frame in flight.
// CONFIGURATION
//   RESP_CHECKSUM_EN defined: extra CHECKSUM state after last payload byte emits one
//     byte = XOR of all preceding frame bytes (opcode included); IDLE follows its transfer.
//     ACK frame becomes 3 bytes, STATUS frame STATUS_BYTES+2.
//   RESP_CHECKSUM_EN undefined: no CHECKSUM state; frames end after payload.
// TESTING
//   1 ack_cmd=8'hA1 pulsed, cmd_out_ready=1 -> bytes C0,A1 on consecutive cycles; ack_ready 1 cycle.
//   2 err_cmd=8'h55, ack_cmd=8'hB0, status all valid same cycle -> ERR{E0,55}, then ACK{C0,B0},
//     then STATUS; each ready asserted only when selected.
//   3 status_data=32'h12345678, ready held 0 for 3 cycles at each byte -> D0,12,34,56,78,
//     data stable while stalled, no bytes duplicated or lost.
//   4 rstn asserted after header of STATUS sent -> valid=0, data=0 immediately; after release
//     idle until next request; next ACK frame clean.
//   5 Continuous ack_valid with ready=1 -> C0,cmd,bubble,C0,cmd...; throughput 2 bytes/3 cycles.
//   6 RESP_CHECKSUM_EN, ack_cmd=8'hA0 -> C0,A0,60; STATUS 32'h01020304 -> D0,01,02,03,04,D4.

Source files
------------

// File: rtl/command_response_tx.sv
// Response framer for the host command byte stream: ACK/ERR/STATUS frames sent byte-serially on cmd_out.
// Optional trailing XOR checksum byte is enabled by defining RESP_CHECKSUM_EN.
module command_response_tx #(
    parameter int         STATUS_BYTES = 4,
    parameter logic [7:0] OP_ACK       = 8'hC0,
    parameter logic [7:0] OP_ERR       = 8'hE0,
    parameter logic [7:0] OP_STATUS    = 8'hD0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ack_valid,
    output logic                      ack_ready,
    input  logic [7:0]                ack_cmd,
    input  logic                      err_valid,
    output logic                      err_ready,
    input  logic [7:0]                err_cmd,
    input  logic                      status_valid,
    output logic                      status_ready,
    input  logic [STATUS_BYTES*8-1:0] status_data,
    output logic                      cmd_out_valid,
    input  logic                      cmd_out_ready,
    output logic [7:0]                cmd_out_data
);

    localparam int PW = STATUS_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic            stat_q, stat_d;
    logic            xfer_s;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    assign xfer_s        = valid_q && cmd_out_ready;
    assign cmd_out_valid = valid_q;
    assign cmd_out_data  = data_q;

    // State register and registered output byte; payload is held left-aligned and shifted out MSB first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= 4'd0;
            pay_q   <= '0;
            stat_q  <= 1'b0;
`ifdef RESP_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            stat_q  <= stat_d;
`ifdef RESP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Request arbitration and frame sequencing; the next output byte is loaded as the current one transfers
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        pay_d        = pay_q;
        stat_d       = stat_q;
        ack_ready    = 1'b0;
        err_ready    = 1'b0;
        status_ready = 1'b0;
`ifdef RESP_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (err_valid) begin
                    err_ready = 1'b1;
                    data_d    = OP_ERR;
                    pay_d     = PW'(err_cmd) << (PW - 8);
                    stat_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = HEADER;
                end else if (ack_valid) begin
                    ack_ready = 1'b1;
                    data_d    = OP_ACK;
                    pay_d     = PW'(ack_cmd) << (PW - 8);
                    stat_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = HEADER;
                end else if (status_valid) begin
                    status_ready = 1'b1;
                    data_d       = OP_STATUS;
                    pay_d        = status_data;
                    stat_d       = 1'b1;
                    valid_d      = 1'b1;
                    state_d      = HEADER;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (xfer_s) begin
                    state_d = PAYLOAD;
                    data_d  = pay_q[PW-1 -: 8];
                    pay_d   = pay_q << 4'd8;
                    cnt_d   = stat_q ? 4'(STATUS_BYTES - 1) : 4'd0;
`ifdef RESP_CHECKSUM_EN
                    csum_d  = data_q;
`endif
                end else begin
                    state_d = HEADER;
                end
            end
            PAYLOAD: begin
                if (xfer_s) begin
                    if (cnt_q == 4'd0) begin
`ifdef RESP_CHECKSUM_EN
                        state_d = CHECKSUM;
                        data_d  = csum_q ^ data_q;
`else
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = 8'h00;
`endif
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                        data_d = pay_q[PW-1 -: 8];
                        pay_d  = pay_q << 4'd8;
`ifdef RESP_CHECKSUM_EN
                        csum_d = csum_q ^ data_q;
`endif
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
`ifdef RESP_CHECKSUM_EN
            CHECKSUM: begin
                if (xfer_s) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = 8'h00;
                end else begin
                    state_d = CHECKSUM;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_command_response_tx.sv
// Directed bench for command_response_tx: framing, priority, stalls, reset abort, back-to-back throughput.
// Define RESP_CHECKSUM_EN to also expect the trailing checksum byte on every frame.
module tb_command_response_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ack_valid, ack_ready, err_valid, err_ready, status_valid, status_ready;
    logic [7:0]  ack_cmd, err_cmd, cmd_out_data;
    logic [31:0] status_data;
    logic        cmd_out_valid, cmd_out_ready;

    int errors = 0;
    int checks = 0;

    command_response_tx dut (
        .clk(clk), .rstn(rstn),
        .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_cmd(ack_cmd),
        .err_valid(err_valid), .err_ready(err_ready), .err_cmd(err_cmd),
        .status_valid(status_valid), .status_ready(status_ready), .status_data(status_data),
        .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready), .cmd_out_data(cmd_out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {31'd0, cmd_out_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, cmd_out_data}, {24'd0, exp});
    endtask

`ifdef RESP_CHECKSUM_EN
`define TAIL(c) begin step(); chk_byte("csum", c); end
`else
`define TAIL(c) begin end
`endif

    logic [7:0] exp_q[$];

    initial begin
        rstn = 1'b0; ack_valid = 1'b0; err_valid = 1'b0; status_valid = 1'b0;
        ack_cmd = 8'h00; err_cmd = 8'h00; status_data = 32'h0; cmd_out_ready = 1'b0;
        #12;
        chk("rst_valid", {31'd0, cmd_out_valid}, 32'd0);
        chk("rst_data", {24'd0, cmd_out_data}, 32'd0);
        chk("rst_readies", {29'd0, ack_ready, err_ready, status_ready}, 32'd0);
        step(); rstn = 1'b1;

        // 1: single ACK
        step(); ack_valid = 1'b1; ack_cmd = 8'hA1; cmd_out_ready = 1'b1; #1;
        chk("t1_ack_ready", {31'd0, ack_ready}, 32'd1);
        chk("t1_idle_valid", {31'd0, cmd_out_valid}, 32'd0);
        step(); ack_valid = 1'b0; ack_cmd = 8'hFF; #1;
        chk_byte("t1_hdr", 8'hC0);
        chk("t1_ack_ready_busy", {31'd0, ack_ready}, 32'd0);
        step(); chk_byte("t1_pay", 8'hA1);
        `TAIL(8'h61)
        step(); chk("t1_end", {31'd0, cmd_out_valid}, 32'd0);

        // 2: simultaneous requests, priority err > ack > status
        err_valid = 1'b1; err_cmd = 8'h55; ack_valid = 1'b1; ack_cmd = 8'hB0;
        status_valid = 1'b1; status_data = 32'hAABBCCDD; #1;
        chk("t2_sel_err", {29'd0, err_ready, ack_ready, status_ready}, 32'b100);
        step(); err_valid = 1'b0; #1;
        chk_byte("t2_err_hdr", 8'hE0);
        chk("t2_busy_readies", {29'd0, err_ready, ack_ready, status_ready}, 32'b000);
        step(); chk_byte("t2_err_pay", 8'h55);
        `TAIL(8'hB5)
        step();
        chk("t2_bubble1", {31'd0, cmd_out_valid}, 32'd0);
        chk("t2_sel_ack", {29'd0, err_ready, ack_ready, status_ready}, 32'b010);
        step(); ack_valid = 1'b0; #1;
        chk_byte("t2_ack_hdr", 8'hC0);
        step(); chk_byte("t2_ack_pay", 8'hB0);
        `TAIL(8'h70)
        step();
        chk("t2_bubble2", {31'd0, cmd_out_valid}, 32'd0);
        chk("t2_sel_status", {29'd0, err_ready, ack_ready, status_ready}, 32'b001);
        step(); status_valid = 1'b0; #1;
        chk_byte("t2_st_hdr", 8'hD0);
        step(); chk_byte("t2_st_b3", 8'hAA);
        step(); chk_byte("t2_st_b2", 8'hBB);
        step(); chk_byte("t2_st_b1", 8'hCC);
        step(); chk_byte("t2_st_b0", 8'hDD);
        `TAIL(8'hD0)
        step(); chk("t2_end", {31'd0, cmd_out_valid}, 32'd0);

        // 3: STATUS with 3-cycle stall on every byte; input changes after accept are ignored
        cmd_out_ready = 1'b0; status_valid = 1'b1; status_data = 32'h12345678; #1;
        chk("t3_status_ready", {31'd0, status_ready}, 32'd1);
        step(); status_valid = 1'b0; status_data = 32'hFFFFFFFF; #1;
        exp_q = '{8'hD0, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef RESP_CHECKSUM_EN
        exp_q.push_back(8'hD8);
`endif
        foreach (exp_q[b]) begin
            for (int k = 0; k < 3; k++) begin
                chk_byte($sformatf("t3_stall_b%0d_c%0d", b, k), exp_q[b]);
                step();
            end
            cmd_out_ready = 1'b1; #1;
            chk_byte($sformatf("t3_xfer_b%0d", b), exp_q[b]);
            step(); cmd_out_ready = 1'b0; #1;
        end
        chk("t3_end", {31'd0, cmd_out_valid}, 32'd0);

        // 4: reset after STATUS header transferred
        cmd_out_ready = 1'b1; status_valid = 1'b1; status_data = 32'hCAFEF00D; #1;
        step(); status_valid = 1'b0; #1;
        chk_byte("t4_hdr", 8'hD0);
        step(); chk_byte("t4_b3", 8'hCA);
        rstn = 1'b0; #1;
        chk("t4_rst_valid", {31'd0, cmd_out_valid}, 32'd0);
        chk("t4_rst_data", {24'd0, cmd_out_data}, 32'd0);
        step(); rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("t4_idle%0d", i), {31'd0, cmd_out_valid}, 32'd0);
        end
        ack_valid = 1'b1; ack_cmd = 8'h3C; #1;
        chk("t4_ack_ready", {31'd0, ack_ready}, 32'd1);
        step(); ack_valid = 1'b0; #1;
        chk_byte("t4_ack_hdr", 8'hC0);
        step(); chk_byte("t4_ack_pay", 8'h3C);
        `TAIL(8'hFC)
        step(); chk("t4_end", {31'd0, cmd_out_valid}, 32'd0);

        // 5: continuous ACK requests: header, payload, one bubble, repeat
        ack_valid = 1'b1; ack_cmd = 8'h77; #1;
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("t5_bubble%0d", f), {31'd0, cmd_out_valid}, 32'd0);
            chk($sformatf("t5_ready%0d", f), {31'd0, ack_ready}, 32'd1);
            step(); if (f == 2) ack_valid = 1'b0; #1;
            chk_byte($sformatf("t5_hdr%0d", f), 8'hC0);
            chk($sformatf("t5_busy%0d", f), {31'd0, ack_ready}, 32'd0);
            step(); chk_byte($sformatf("t5_pay%0d", f), 8'h77);
            `TAIL(8'hB7)
            step();
        end
        chk("t5_end", {31'd0, cmd_out_valid}, 32'd0);

        // 6: frame end / checksum on ACK A0 and STATUS 01020304
        ack_valid = 1'b1; ack_cmd = 8'hA0; #1;
        step(); ack_valid = 1'b0; #1;
        chk_byte("t6_ack_hdr", 8'hC0);
        step(); chk_byte("t6_ack_pay", 8'hA0);
        `TAIL(8'h60)
        step(); chk("t6_ack_end", {31'd0, cmd_out_valid}, 32'd0);
        status_valid = 1'b1; status_data = 32'h01020304; #1;
        step(); status_valid = 1'b0; #1;
        chk_byte("t6_st_hdr", 8'hD0);
        step(); chk_byte("t6_st_b3", 8'h01);
        step(); chk_byte("t6_st_b2", 8'h02);
        step(); chk_byte("t6_st_b1", 8'h03);
        step(); chk_byte("t6_st_b0", 8'h04);
        `TAIL(8'hD4)
        step(); chk("t6_st_end", {31'd0, cmd_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
